// File: rtl/apb_pkg.sv
// Shared types and register-map constants for the APB initiator and the
// responders it talks to (timer block).
package apb_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } e_rw;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } e_apb_state;

  // Timer register map
  localparam int unsigned CTR_STATUS_ADDR = 0;
  localparam int unsigned CTR_GOAL_ADDR   = 1;
  localparam int unsigned CTR_CURR_ADDR   = 2;

  // Timer status register fields
  localparam int unsigned STATUS_START_BIT = 0;
  localparam int unsigned STATUS_STOP_BIT  = 1;
  localparam int unsigned STATUS_STATE_LSB = 2;
  localparam int unsigned STATUS_STATE_MSB = 3;

endpackage

// File: rtl/apb_wait_ctr.sv
// Clearable saturating wait-state counter; hit flags the increment that
// reaches MAX so the caller can act on that same edge. MAX=0 never hits.
module apb_wait_ctr #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != W'(MAX))) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = (MAX != 0) && inc && (count_q == W'(MAX - 1));

endmodule

// File: rtl/apb_master.sv
// APB initiator: converts a valid/ready command into one APB transfer and
// returns a single-cycle response, aborting if pready stays low too long.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  e_apb_state state_q, state_d;

  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic wait_clr, wait_inc, wait_hit;

  assign wait_clr = (state_q == IDLE) && cmd_valid;
  assign wait_inc = (state_q == ACCESS) && !pready;

  apb_wait_ctr #(
    .MAX(TIMEOUT)
  ) u_wait_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .hit  (wait_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || wait_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs.
  always_comb begin
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    if ((state_q == IDLE) && cmd_valid) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      if (e_rw'(cmd_write) == WRITE) pwdata_d = cmd_wdata;
    end
    // pready wins over a simultaneous timeout hit.
    if ((state_q == ACCESS) && (pready || wait_hit)) begin
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = !pready;
      rsp_err_d     = pready ? pslverr : 1'b1;
      rsp_rdata_d   = (pready && (e_rw'(pwrite_q) == READ)) ? prdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level model predicts every
// output each cycle from the accept time and the responder's planned waits.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [7:0]  rsp_rdata, pwdata;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [7:0]  prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(8),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, n_print = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
    end
  endtask

  // Model state: cyc counts rising edges; a transfer accepted at edge acc
  // shows SETUP after that edge, then len ACCESS cycles, then the response.
  int          cyc = 0, acc = 0, len = 0, acc_cnt = 0;
  logic        busy = 1'b0, m_init = 1'b0;
  int          cur_w = 0, pl_w = 0;
  logic        cur_err = 1'b0, cur_write = 1'b0, pl_err = 1'b0;
  logic [7:0]  cur_rdata = '0, pl_rdata = '0;
  logic        e_cmd_ready = 1'b0, e_psel = 1'b0, e_penable = 1'b0, e_pwrite = 1'b0;
  logic [31:0] e_paddr = '0;
  logic [7:0]  e_pwdata = '0, e_rsp_rdata = '0;
  logic        e_rsp_valid = 1'b0, e_rsp_err = 1'b0, e_rsp_to = 1'b0;
  logic [7:0]  mem[16];

  initial begin : model
    forever begin
      @(posedge clk);
      cyc++;
      e_rsp_valid = 1'b0;
      if (reset) begin
        busy = 1'b0; m_init = 1'b1;
        e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0;
        e_rsp_rdata = '0; e_rsp_err = 1'b0; e_rsp_to = 1'b0;
      end else if (busy && cyc == acc + len + 1) begin
        busy = 1'b0;
        e_rsp_valid = 1'b1;
        if (cur_w >= TO) begin
          e_rsp_err = 1'b1; e_rsp_to = 1'b1; e_rsp_rdata = '0;
        end else begin
          e_rsp_err = cur_err; e_rsp_to = 1'b0;
          e_rsp_rdata = cur_write ? 8'h00 : cur_rdata;
        end
      end else if (!busy && cmd_valid) begin
        busy = 1'b1; acc = cyc; acc_cnt++;
        cur_w = pl_w; cur_err = pl_err; cur_rdata = pl_rdata; cur_write = cmd_write;
        len = (cur_w >= TO) ? TO : cur_w + 1;
        e_paddr = cmd_addr; e_pwrite = cmd_write;
        if (cmd_write) e_pwdata = cmd_wdata;
      end
      e_psel = busy;
      e_penable = busy && (cyc > acc);
      e_cmd_ready = !busy;
    end
  end

  // Responder: pready rises on ACCESS cycle index cur_w; noise elsewhere.
  initial begin : responder
    int k;
    forever begin
      @(negedge clk);
      k = cyc - acc - 1;
      if (busy && cyc > acc && k == cur_w) begin
        pready = 1'b1; pslverr = cur_err; prdata = cur_rdata;
      end else begin
        pready  = (busy && cyc > acc) ? 1'b0 : 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = 8'($urandom);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
        check("psel", 32'(psel), 32'(e_psel));
        check("penable", 32'(penable), 32'(e_penable));
        check("paddr", paddr, e_paddr);
        check("pwrite", 32'(pwrite), 32'(e_pwrite));
        check("pwdata", 32'(pwdata), 32'(e_pwdata));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e_rsp_rdata));
        check("rsp_err", 32'(rsp_err), 32'(e_rsp_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e_rsp_to));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge right after acceptance.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                      input int w, input logic err, input logic [7:0] rd, input logic hold);
    int n0;
    pl_w = w; pl_err = err; pl_rdata = rd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n0 = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt == n0; i++) @(negedge clk);
    if (acc_cnt == n0) check("accept_bound", 32'(acc_cnt), 32'(n0 + 1));
    if (!hold) begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom);
      cmd_addr = $urandom; cmd_wdata = 8'($urandom);
    end
  endtask

  task automatic wr_cmd(input logic [31:0] addr, input logic [7:0] d, input int w,
                        input logic err, input logic hold);
    if (!err && w < TO) mem[addr[3:0]] = d;
    send(1'b1, addr, d, w, err, 8'($urandom), hold);
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input int w, input logic err,
                        input logic hold);
    send(1'b0, addr, 8'($urandom), w, err, mem[addr[3:0]], hold);
  endtask

  // Latency in the N+k numbering: acceptance edge N, response in cycle N+k.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        lat = cyc - acc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int lat, a0, a1, a2;
    logic seen;
    logic [7:0] status_val;
    logic [31:0] ra;
    logic rw, rerr, rhold;
    int rwait;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_psel", 32'(psel), 32'd0);

    wr_cmd(CTR_GOAL_ADDR, 8'd25, 0, 1'b0, 1'b0);
    wait_rsp(lat);
    check("lat_zero_wait", 32'(lat), 32'd3);
    check("write_err", 32'(rsp_err), 32'd0);
    rd_cmd(CTR_GOAL_ADDR, 0, 1'b0, 1'b0);
    wait_rsp(lat);
    check("read_back", 32'(rsp_rdata), 32'd25);

    wr_cmd(32'd2, 8'h5A, 3, 1'b0, 1'b0);
    wait_rsp(lat);
    check("lat_3_waits", 32'(lat), 32'd6);

    send(1'b0, 32'd3, 8'h00, 0, 1'b1, 8'hAA, 1'b0);
    wait_rsp(lat);
    check("slverr_err", 32'(rsp_err), 32'd1);
    check("slverr_to", 32'(rsp_timeout), 32'd0);
    check("slverr_rdata", 32'(rsp_rdata), 32'hAA);

    rd_cmd(32'd5, 1000, 1'b0, 1'b0);
    wait_rsp(lat);
    check("lat_timeout", 32'(lat), 32'd18);
    check("timeout_flag", 32'(rsp_timeout), 32'd1);
    check("timeout_rdata", 32'(rsp_rdata), 32'd0);
    wr_cmd(32'd6, 8'h33, 1, 1'b0, 1'b0);
    wait_rsp(lat);
    check("after_timeout_to", 32'(rsp_timeout), 32'd0);
    rd_cmd(32'd6, TO - 1, 1'b0, 1'b0);
    wait_rsp(lat);
    check("lat_edge_ready", 32'(lat), 32'd18);
    check("edge_ready_to", 32'(rsp_timeout), 32'd0);
    check("edge_ready_rdata", 32'(rsp_rdata), 32'h33);

    status_val = 8'(1 << STATUS_START_BIT) | 8'(2'b01 << STATUS_STATE_LSB);
    wr_cmd(CTR_STATUS_ADDR, status_val, 0, 1'b0, 1'b0);
    wait_rsp(lat);
    rd_cmd(CTR_STATUS_ADDR, 1, 1'b0, 1'b0);
    wait_rsp(lat);
    check("status_state", 32'(rsp_rdata[STATUS_STATE_MSB:STATUS_STATE_LSB]), 32'd1);
    check("status_stop", 32'(rsp_rdata[STATUS_STOP_BIT]), 32'd0);

    rd_cmd(CTR_CURR_ADDR, 10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_psel", 32'(psel), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("reset_mid_no_rsp", 32'(seen), 32'd0);

    wr_cmd(32'd7, 8'h11, 0, 1'b0, 1'b1);
    a0 = acc;
    wr_cmd(32'd8, 8'h22, 0, 1'b0, 1'b1);
    a1 = acc;
    rd_cmd(32'd7, 0, 1'b0, 1'b1);
    a2 = acc;
    cmd_valid = 1'b0;
    check("b2b_interval_1", 32'(a1 - a0), 32'd3);
    check("b2b_interval_2", 32'(a2 - a1), 32'd3);
    repeat (4) @(negedge clk);

    for (int t = 0; t < 250; t++) begin
      rw    = 1'($urandom);
      rerr  = ($urandom_range(0, 3) == 0);
      rhold = 1'($urandom);
      rwait = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20))
                                          : int'($urandom_range(0, 3));
      ra    = $urandom;
      if (rw) wr_cmd(ra, 8'($urandom), rwait, rerr, rhold);
      else rd_cmd(ra, rwait, rerr, rhold);
      if (!rhold) repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
